// File: rtl/ps_mem_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port among N masters: one burst in
// flight, addresses remapped into the DRAM window, beat count checked vs len.
module ps_mem_rd_arbiter #(
  parameter int unsigned N        = 2,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WIN_BITS = 28,
  parameter logic [31:0] REMAP_HI = 32'd1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N-1:0]        m_ar_valid,
  output logic [N-1:0]        m_ar_ready,
  input  logic [N*32-1:0]     m_ar_addr,
  input  logic [N*8-1:0]      m_ar_len,
  input  logic [N*3-1:0]      m_ar_size,
  input  logic [N*2-1:0]      m_ar_burst,
  input  logic [N*ID_W-1:0]   m_ar_id,
  output logic [N-1:0]        m_r_valid,
  input  logic [N-1:0]        m_r_ready,
  output logic [DATA_W-1:0]   m_r_data,
  output logic [1:0]          m_r_resp,
  output logic                m_r_last,
  output logic [ID_W-1:0]     m_r_id,
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  output logic [31:0]         s_ar_addr,
  output logic [7:0]          s_ar_len,
  output logic [2:0]          s_ar_size,
  output logic [1:0]          s_ar_burst,
  output logic [ID_W-1:0]     s_ar_id,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_last,
  input  logic [ID_W-1:0]     s_r_id,
  output logic [N-1:0]        grant,
  output logic                len_err
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [ID_W-1:0] id;
  } ar_t;

  state_t           state_q, state_d;
  ar_t              ar_q, ar_d, sel_ar;
  logic [N-1:0]     grant_q, grant_d, pick_oh;
  logic [IDX_W-1:0] cur_q, cur_d, rr_q, rr_d, pick, cand;
  logic [8:0]       beats_q, beats_d, beats_inc, beats_tgt;
  logic             len_err_q, len_err_d;
  logic             found, r_hs;
  logic             unused_addr_hi;

  // First requester after the rr pointer, cyclically
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % N);
      if (!found && m_ar_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // One-hot of the pick and its payload slice
  always_comb begin
    pick_oh = '0;
    sel_ar  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (found && pick == IDX_W'(i)) begin
        pick_oh[i]   = 1'b1;
        sel_ar.addr  = m_ar_addr[32*i +: 32];
        sel_ar.len   = m_ar_len[8*i +: 8];
        sel_ar.size  = m_ar_size[3*i +: 3];
        sel_ar.burst = m_ar_burst[2*i +: 2];
        sel_ar.id    = m_ar_id[ID_W*i +: ID_W];
      end
    end
  end

  assign unused_addr_hi = ^sel_ar.addr[31:WIN_BITS];

  assign r_hs      = s_r_valid && s_r_ready;
  assign beats_inc = (beats_q == 9'h1FF) ? beats_q : beats_q + 9'd1;
  assign beats_tgt = {1'b0, ar_q.len} + 9'd1;

  // Next-state and next-register values
  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    grant_d   = grant_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    beats_d   = beats_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ADDR;
          grant_d    = pick_oh;
          cur_d      = pick;
          beats_d    = '0;
          ar_d       = sel_ar;
          ar_d.addr  = {REMAP_HI[31-WIN_BITS:0], sel_ar.addr[WIN_BITS-1:0]};
        end
      end
      ADDR: begin
        if (s_ar_ready) state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          beats_d = beats_inc;
          if (s_r_last) begin
            if (beats_inc != beats_tgt) len_err_d = 1'b1;
            state_d = IDLE;
            rr_d    = cur_q;
            grant_d = '0;
          end else if (beats_inc == beats_tgt) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ar_q      <= '0;
      grant_q   <= '0;
      cur_q     <= '0;
      rr_q      <= IDX_W'(N - 1);
      beats_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      grant_q   <= grant_d;
      cur_q     <= cur_d;
      rr_q      <= rr_d;
      beats_q   <= beats_d;
      len_err_q <= len_err_d;
    end
  end

  // Request accept is a single-cycle pulse while idle
  assign m_ar_ready = (state_q == IDLE) ? pick_oh : '0;

  assign s_ar_valid = (state_q == ADDR);
  assign s_ar_addr  = ar_q.addr;
  assign s_ar_len   = ar_q.len;
  assign s_ar_size  = ar_q.size;
  assign s_ar_burst = ar_q.burst;
  assign s_ar_id    = ar_q.id;

  // Only valid/ready are steered; R payload is broadcast
  assign m_r_valid = (state_q == DATA) ? (grant_q & {N{s_r_valid}}) : '0;
  assign s_r_ready = (state_q == DATA) && |(grant_q & m_r_ready);
  assign m_r_data  = s_r_data;
  assign m_r_resp  = s_r_resp;
  assign m_r_last  = s_r_last;
  assign m_r_id    = s_r_id;

  assign grant   = grant_q;
  assign len_err = len_err_q;

endmodule

// File: doc/ps_mem_rd_arbiter.md
Name: ps_mem_rd_arbiter

Overview:
- Read-channel arbiter sharing the PS DDR slave AXI read port (S_AXI_ar*/r*) between N fabric masters, e.g. the Rocket mem port and a boot/DMA loader.
- Round-robin grant, one burst in flight at a time.
- Remaps each master address into the Rocket DRAM window (upper bits forced to REMAP_HI).
- Checks each burst's beat count against its len.

Parameters:
N, 2, number of requesting masters (2..8)
ID_W, 6, AXI ID width
DATA_W, 64, read data width
WIN_BITS, 28, address bits passed through unchanged
REMAP_HI, 4'd1, value forced onto addr[31:WIN_BITS]

Ports:
clock  in  1  single clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
m_ar_valid  in  N  per-master AR valid
m_ar_ready  out  N  per-master AR ready (one-hot pulse)
m_ar_addr  in  N*32  packed addresses, master i at [32i+31:32i]
m_ar_len  in  N*8  packed burst lengths
m_ar_size  in  N*3  packed burst sizes
m_ar_burst  in  N*2  packed burst types
m_ar_id  in  N*ID_W  packed IDs
m_r_valid  out  N  per-master R valid
m_r_ready  in  N  per-master R ready
m_r_data  out  DATA_W  R data, broadcast to all masters
m_r_resp  out  2  R resp, broadcast
m_r_last  out  1  R last, broadcast
m_r_id  out  ID_W  R id, broadcast
s_ar_valid  out  1  to PS slave
s_ar_ready  in  1
s_ar_addr  out  32  remapped address
s_ar_len  out  8
s_ar_size  out  3
s_ar_burst  out  2
s_ar_id  out  ID_W
s_r_valid  in  1
s_r_ready  out  1
s_r_data  in  DATA_W
s_r_resp  in  2
s_r_last  in  1
s_r_id  in  ID_W
grant  out  N  one-hot owner of current burst, 0 when idle
len_err  out  1  sticky beat-count mismatch flag

Behaviour:
- Reset (reset_n=0 at edge), from any state including mid-burst:
  - state=IDLE; s_ar_valid=0, m_ar_ready=0, grant=0, len_err=0.
  - s_ar_* payload registers = 0; beat counter = 0.
  - rr pointer = N-1, so master 0 has first priority.
  - An in-flight slave burst is abandoned; the PS side must also be reset.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_ar_valid is set, grant g = the first requesting index after the rr pointer, cyclic.
  - In the same cycle: m_ar_ready[g]=1 (combinational, one cycle only); capture len/size/burst/id; capture s_ar_addr = {REMAP_HI, addr_g[WIN_BITS-1:0]}.
  - Next state ADDR; grant register = onehot(g).
- ADDR:
  - s_ar_valid=1 with stable payload until s_ar_ready.
  - On the handshake, next state DATA; s_ar_valid=0 the following cycle.
- DATA:
  - m_r_valid[g]=s_r_valid and s_r_ready=m_r_ready[g], combinational passthrough with zero latency.
  - m_r_valid is 0 for all other masters.
  - Beat counter increments on each R handshake.
  - On the handshake with s_r_last=1: if beats != len+1, set len_err (sticky until reset). Next state IDLE; rr pointer = g; grant=0.
  - If beats reach len+1 without s_r_last, set len_err and stay in DATA until s_r_last.
  - Beat counter is 9 bits and saturates at 511.
- Latency:
  - m_ar accepted at cycle T means s_ar_valid is high at T+1.
  - Back-to-back bursts: s_r_last handshake at T, next m_ar_ready at T+1, s_ar_valid at T+2.
- No request is accepted outside IDLE; m_ar_ready is 0 in ADDR and DATA.
- m_r_data/resp/last/id always equal s_r_*; only valid/ready are steered.
- Fairness: with all N masters requesting continuously, each master is granted once every N bursts.
- A master dropping m_ar_valid before ready is an AXI violation and is not handled.

Test Plan:
- Single master: m0 requests addr 0x0000_1000, len 3 -> s_ar_addr 0x1000_1000 and s_ar_len 3 one cycle after m_ar_ready[0]; 4 R beats routed to m0 only; back to IDLE; len_err=0.
- Contention: m0 and m1 both hold valid from reset -> grants in order m0, m1, m0, m1 over 4 bursts; grant stays one-hot throughout.
- Backpressure: s_ar_ready low for 5 cycles -> s_ar_valid and payload held stable; then m_r_ready[1] toggling -> s_r_ready mirrors it and no beat is lost (beat count 8 for len 7).
- Length error: len 3 but s_r_last on beat 2 -> len_err=1 after that handshake, stays 1 through later good bursts, cleared only by reset_n=0.
- Remap: addr 0xFFFF_FFF0 -> s_ar_addr 0x1FFF_FFF0.
- Reset mid-burst: reset_n=0 during DATA beat 2 -> next cycle state IDLE, grant=0, s_ar_valid=0, s_r_ready=0; after release, m0 is granted first.
